// File: rtl/mem_order_ctrl_if.sv
// ============================================================================
// Module   : mem_order_ctrl_if
// Brief    : ID-stage decode flags, memory traffic strobes and ordering-control
//            outputs shared between the pipeline and mem_order_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_order_ctrl_if #(
    parameter int max_out_p = 16
);
    logic                               instr_v_i;
    logic                               is_mem_op_i;
    logic                               is_fence_op_i;
    logic                               is_fence_i_op_i;
    logic                               op_is_swap_aq_i;
    logic                               op_is_swap_rl_i;
    logic                               op_is_lr_acq_i;
    logic                               issue_ready_i;
    logic                               mem_req_sent_i;
    logic                               mem_resp_i;
    logic                               stall_o;
    logic                               icache_flush_o;
    logic [$clog2(max_out_p+1)-1:0]     out_count_o;
    logic                               error_o;

    modport master (
        output instr_v_i, is_mem_op_i, is_fence_op_i, is_fence_i_op_i,
               op_is_swap_aq_i, op_is_swap_rl_i, op_is_lr_acq_i,
               issue_ready_i, mem_req_sent_i, mem_resp_i,
        input  stall_o, icache_flush_o, out_count_o, error_o
    );

    modport slave (
        input  instr_v_i, is_mem_op_i, is_fence_op_i, is_fence_i_op_i,
               op_is_swap_aq_i, op_is_swap_rl_i, op_is_lr_acq_i,
               issue_ready_i, mem_req_sent_i, mem_resp_i,
        output stall_o, icache_flush_o, out_count_o, error_o
    );
endinterface

`default_nettype wire

// File: rtl/mem_order_ctrl.sv
// ============================================================================
// Module   : mem_order_ctrl
// Brief    : Tracks outstanding remote memory requests and holds the ID
//            instruction to enforce fence / fence.i / acquire / release order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_order_ctrl #(
    parameter int max_out_p      = 16,
    parameter int flush_cycles_p = 4
) (
    input  wire logic          clk_i,
    input  wire logic          reset_n_i,
    mem_order_ctrl_if.slave    bus
);

    localparam int CW = $clog2(max_out_p + 1);
    localparam int FW = $clog2(flush_cycles_p + 1);

    localparam logic [CW-1:0] c_CNT_MAX   = CW'(max_out_p);
    localparam logic [FW-1:0] c_FLUSH_LEN = FW'(flush_cycles_p);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_ACQ   = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [FW-1:0] r_flush_cnt;
    logic          r_error;

    logic          w_cnt_zero;
    logic          w_cnt_full;
    logic          w_order_op;
    logic          w_stall;
    logic          w_fire;

    assign w_cnt_zero = (r_count == '0);
    assign w_cnt_full = (r_count == c_CNT_MAX);
    assign w_order_op = bus.instr_v_i &
                        (bus.is_fence_op_i | bus.is_fence_i_op_i | bus.op_is_swap_rl_i);

    // Stall never looks at issue_ready_i, which keeps fire free of a loop.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_order_op && !w_cnt_zero)
                    w_stall = 1'b1;
                else if (bus.instr_v_i && bus.is_mem_op_i && w_cnt_full)
                    w_stall = 1'b1;
            end
            c_DRAIN: w_stall = 1'b1;
            c_ACQ:   w_stall = bus.instr_v_i & bus.is_mem_op_i;
            c_FLUSH: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign w_fire = bus.instr_v_i & bus.issue_ready_i & ~w_stall;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_order_op && !w_cnt_zero)
                    w_state_nxt = c_DRAIN;
                else if (w_fire && (bus.op_is_swap_aq_i || bus.op_is_lr_acq_i))
                    w_state_nxt = c_ACQ;
                else if (w_fire && bus.is_fence_i_op_i)
                    w_state_nxt = c_FLUSH;
            end
            // A squashed instruction also releases DRAIN; the held one is re-decoded in IDLE.
            c_DRAIN: begin
                if (w_cnt_zero || !bus.instr_v_i)
                    w_state_nxt = c_IDLE;
            end
            c_ACQ: begin
                if (w_cnt_zero)
                    w_state_nxt = c_IDLE;
            end
            c_FLUSH: begin
                if (r_flush_cnt <= FW'(1))
                    w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= c_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_IDLE && w_state_nxt == c_FLUSH)
                r_flush_cnt <= c_FLUSH_LEN;
            else if (r_state == c_FLUSH && r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - FW'(1);
        end
    end

    // Saturate at both ends and latch a sticky error instead of wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            case ({bus.mem_req_sent_i, bus.mem_resp_i})
                2'b10: begin
                    if (w_cnt_full) r_error <= 1'b1;
                    else            r_count <= r_count + CW'(1);
                end
                2'b01: begin
                    if (w_cnt_zero) r_error <= 1'b1;
                    else            r_count <= r_count - CW'(1);
                end
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.icache_flush_o = (r_state == c_FLUSH);
    assign bus.out_count_o    = r_count;
    assign bus.error_o        = r_error;

endmodule

`default_nettype wire
